// File: rtl/pc_gen.sv
// Program counter generator: BOOT delay, then sequential fetch with trap/redirect/halt control.
// Latency: pc_out, pc_valid and misaligned are registered; pc_next is the combinational next pc_out.
// Backpressure: stall holds pc_out in RUN; trap and redirect override stall, and HALT holds pc_out until resume.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            misaligned,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    state_t          state, state_nxt;
    logic [3:0]      boot_cnt, boot_cnt_nxt;
    logic            pc_valid_nxt;
    logic            misaligned_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            boot_cnt   <= 4'd0;
            pc_out     <= RESET_VECTOR;
            pc_valid   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_cnt   <= boot_cnt_nxt;
            pc_out     <= pc_next;
            pc_valid   <= pc_valid_nxt;
            misaligned <= misaligned_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        boot_cnt_nxt   = boot_cnt;
        pc_next        = pc_out;
        pc_valid_nxt   = pc_valid;
        misaligned_nxt = 1'b0;
        case (state)
            ST_BOOT: begin
                pc_next      = RESET_VECTOR;
                pc_valid_nxt = 1'b0;
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt    = ST_RUN;
                    boot_cnt_nxt = 4'd0;
                    pc_valid_nxt = 1'b1;
                end else begin
                    boot_cnt_nxt = boot_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                pc_valid_nxt = 1'b1;
                if (trap_valid) begin
                    pc_next = TRAP_VECTOR;
                end else if (redirect_valid) begin
                    // A misaligned target is turned into a trap rather than fetched.
                    if (redirect_target[1:0] != 2'b00) begin
                        pc_next        = TRAP_VECTOR;
                        misaligned_nxt = 1'b1;
                    end else begin
                        pc_next = redirect_target;
                    end
                end else if (halt_req) begin
                    state_nxt    = ST_HALT;
                    pc_valid_nxt = 1'b0;
                end else if (!stall) begin
                    pc_next = pc_out + XLEN'(4);
                end
            end
            ST_HALT: begin
                pc_valid_nxt = 1'b0;
                if (resume) begin
                    state_nxt    = ST_RUN;
                    pc_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt    = ST_BOOT;
                boot_cnt_nxt = 4'd0;
                pc_next      = RESET_VECTOR;
                pc_valid_nxt = 1'b0;
            end
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with default parameters.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic        pc_valid;
    logic        misaligned;
    logic [1:0]  state_o;

    int tests_run = 0;
    int tests_failed = 0;

    pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .pc_valid        (pc_valid),
        .misaligned      (misaligned),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_valid      = 1'b0;
        halt_req        = 1'b0;
        resume          = 1'b0;
    endtask

    // Advance through one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs change on the falling edge, well away from the active edge.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic jump_to(input logic [31:0] target);
        to_negedge();
        redirect_valid  = 1'b1;
        redirect_target = target;
        tick();
        to_negedge();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #2;
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0 || state_o !== 2'd0 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pc_out=%h pc_valid=%b state=%0d mis=%b, need 0/0/0/0",
                     pc_out, pc_valid, state_o, misaligned);
        end
        to_negedge();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (pc_valid !== 1'b0 || state_o !== 2'd0 || pc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_edge1: pc_valid=%b state=%0d pc_out=%h, need 0/0/0", pc_valid, state_o, pc_out);
        end
        tests_run++;
        if (pc_next !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_pc_next: got %h need 00000000", pc_next);
        end
        tick();
        tests_run++;
        if (pc_valid !== 1'b1 || state_o !== 2'd1 || pc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_done: pc_valid=%b state=%0d pc_out=%h, need 1/1/0", pc_valid, state_o, pc_out);
        end
        tests_run++;
        if (pc_next !== 32'h4) begin
            tests_failed++;
            $display("FAIL run_pc_next: got %h need 00000004", pc_next);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h4) begin
            tests_failed++;
            $display("FAIL incr_4: got %h need 00000004", pc_out);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h8) begin
            tests_failed++;
            $display("FAIL incr_8: got %h need 00000008", pc_out);
        end
    endtask

    task automatic test_priority();
        jump_to(32'h10);
        tests_run++;
        if (pc_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL redirect_10: got %h need 00000010", pc_out);
        end
        trap_valid      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        stall           = 1'b1;
        halt_req        = 1'b1;
        #1;
        tests_run++;
        if (pc_next !== 32'h100) begin
            tests_failed++;
            $display("FAIL prio_pc_next: got %h need 00000100", pc_next);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h100 || misaligned !== 1'b0 || state_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL trap_priority: pc_out=%h mis=%b state=%0d, need 00000100/0/1", pc_out, misaligned, state_o);
        end
        // Redirect outranks halt_req and stall.
        to_negedge();
        clear_inputs();
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        halt_req        = 1'b1;
        stall           = 1'b1;
        tick();
        tests_run++;
        if (pc_out !== 32'h300 || state_o !== 2'd1 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL redirect_over_halt: pc_out=%h state=%0d vld=%b, need 00000300/1/1", pc_out, state_o, pc_valid);
        end
        to_negedge();
        clear_inputs();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        tick();
        tests_run++;
        if (pc_out !== 32'h300) begin
            tests_failed++;
            $display("FAIL stall_hold: got %h need 00000300", pc_out);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h300 || pc_next !== 32'h300) begin
            tests_failed++;
            $display("FAIL stall_hold2: pc_out=%h pc_next=%h need 00000300", pc_out, pc_next);
        end
        to_negedge();
        stall = 1'b0;
        tick();
        tests_run++;
        if (pc_out !== 32'h304) begin
            tests_failed++;
            $display("FAIL stall_release: got %h need 00000304", pc_out);
        end
    endtask

    task automatic test_misaligned();
        to_negedge();
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        tick();
        tests_run++;
        if (pc_out !== 32'h100 || misaligned !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_redirect: pc_out=%h mis=%b, need 00000100/1", pc_out, misaligned);
        end
        to_negedge();
        clear_inputs();
        tick();
        tests_run++;
        if (pc_out !== 32'h104 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_pulse: pc_out=%h mis=%b, need 00000104/0", pc_out, misaligned);
        end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        tests_run++;
        if (pc_out !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("FAIL wrap_setup: got %h need fffffffc", pc_out);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_around: pc_out=%h vld=%b, need 00000000/1", pc_out, pc_valid);
        end
    endtask

    task automatic test_halt_resume();
        jump_to(32'h40);
        halt_req = 1'b1;
        tick();
        tests_run++;
        if (state_o !== 2'd2 || pc_valid !== 1'b0 || pc_out !== 32'h40) begin
            tests_failed++;
            $display("FAIL halt_enter: state=%0d vld=%b pc_out=%h, need 2/0/00000040", state_o, pc_valid, pc_out);
        end
        to_negedge();
        clear_inputs();
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        trap_valid      = 1'b1;
        #1;
        tests_run++;
        if (pc_next !== 32'h40) begin
            tests_failed++;
            $display("FAIL halt_pc_next: got %h need 00000040", pc_next);
        end
        tick();
        tests_run++;
        if (state_o !== 2'd2 || pc_out !== 32'h40 || pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_ignore: state=%0d pc_out=%h vld=%b, need 2/00000040/0", state_o, pc_out, pc_valid);
        end
        to_negedge();
        clear_inputs();
        resume   = 1'b1;
        halt_req = 1'b1;
        tick();
        tests_run++;
        if (state_o !== 2'd1 || pc_out !== 32'h40 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume: state=%0d pc_out=%h vld=%b, need 1/00000040/1", state_o, pc_out, pc_valid);
        end
        to_negedge();
        clear_inputs();
        tick();
        tests_run++;
        if (pc_out !== 32'h44) begin
            tests_failed++;
            $display("FAIL after_resume: got %h need 00000044", pc_out);
        end
    endtask

    task automatic test_async_reset();
        jump_to(32'h80);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: pc_out=%h vld=%b state=%0d, need 0/0/0", pc_out, pc_valid, state_o);
        end
        // Events during and right after reset must not leak into BOOT.
        trap_valid      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        halt_req        = 1'b1;
        tick();
        to_negedge();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0 || state_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL boot_ignore: pc_out=%h vld=%b state=%0d, need 0/0/0", pc_out, pc_valid, state_o);
        end
        to_negedge();
        clear_inputs();
        tick();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b1 || state_o !== 2'd1) begin
            tests_failed++;
            $display("FAIL reboot: pc_out=%h vld=%b state=%0d, need 0/1/1", pc_out, pc_valid, state_o);
        end
        tick();
        tests_run++;
        if (pc_out !== 32'h4) begin
            tests_failed++;
            $display("FAIL reboot_incr: got %h need 00000004", pc_out);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall();
        test_misaligned();
        test_wrap();
        test_halt_resume();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of all address ports.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100: address loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter BOOT_CYCLES, default 2, legal range 1-15: cycles held in BOOT before fetching.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port stall, input, 1 bit: hold pc_out this cycle.
REQ-008 SHALL have port redirect_valid, input, 1 bit: branch or jump taken.
REQ-009 SHALL have port redirect_target, input, XLEN bits: branch or jump destination.
REQ-010 SHALL have port trap_valid, input, 1 bit: exception or interrupt request.
REQ-011 SHALL have port halt_req, input, 1 bit: request to enter HALT.
REQ-012 SHALL have port resume, input, 1 bit: leave HALT.
REQ-013 SHALL have port pc_out, output, XLEN bits: registered current fetch address.
REQ-014 SHALL have port pc_next, output, XLEN bits: combinational value pc_out takes at the next edge.
REQ-015 SHALL have port pc_valid, output, 1 bit: registered; pc_out is a valid fetch address.
REQ-016 SHALL have port misaligned, output, 1 bit: registered one-cycle pulse on a misaligned redirect.
REQ-017 SHALL have port state_o, output, 2 bits: current state; BOOT=0, RUN=1, HALT=2.

Function
REQ-018 SHALL implement three states: BOOT, RUN, HALT. Encoding 3 is illegal and SHALL recover to BOOT at the next edge.
REQ-019 In BOOT, a boot counter SHALL increment each cycle while pc_out holds RESET_VECTOR and pc_valid=0.
REQ-020 When the boot counter reaches BOOT_CYCLES-1, BOOT SHALL transition to RUN at that edge, with pc_valid=1 and pc_out=RESET_VECTOR.
REQ-021 In BOOT, stall, redirect_valid, trap_valid, halt_req and resume SHALL all be ignored.
REQ-022 In RUN, event priority per cycle SHALL be, highest first: trap_valid, redirect_valid, halt_req, stall, increment.
REQ-023 A RUN trap SHALL load pc_out=TRAP_VECTOR at the next edge, regardless of stall.
REQ-024 A RUN redirect with redirect_target[1:0]==0 SHALL load pc_out=redirect_target at the next edge, regardless of stall.
REQ-025 A RUN redirect with redirect_target[1:0]!=0 SHALL load pc_out=TRAP_VECTOR and pulse misaligned=1 for exactly one cycle.
REQ-026 A RUN halt_req (no trap or redirect that cycle) SHALL move to HALT, hold pc_out, and set pc_valid=0 at the next edge.
REQ-027 A RUN stall (no higher-priority event) SHALL hold pc_out.
REQ-028 Otherwise in RUN, pc_out SHALL advance to pc_out+4, wrapping modulo 2^XLEN with no flag.
REQ-029 In HALT, pc_out SHALL hold; stall, redirect_valid, trap_valid and halt_req SHALL be ignored.
REQ-030 In HALT, resume=1 SHALL return to RUN at the next edge with pc_valid=1 and pc_out unchanged.
REQ-031 Simultaneous halt_req and resume in HALT SHALL resume.
REQ-032 pc_next SHALL always equal the value pc_out takes at the next rising edge, including in BOOT and HALT.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, set: state BOOT, boot counter 0, pc_out=RESET_VECTOR, pc_valid=0, misaligned=0.
REQ-034 A reset asserted mid-operation, from any state, SHALL discard all pending events.
REQ-035 After rst_n deasserts, the first edge SHALL begin BOOT counting.

Verification
REQ-036 Reset behaviour: release rst_n with BOOT_CYCLES=2 -> pc_valid rises after 2 edges with pc_out=0x0; subsequent edges give 0x4, 0x8.
REQ-037 Priority: in RUN at pc 0x10, trap_valid=1, redirect_valid=1 to 0x200, and stall=1 in the same cycle -> pc_out=0x100 next cycle.
REQ-038 Misaligned redirect: redirect_target=0x202 -> pc_out=0x100 and misaligned=1 for one cycle only.
REQ-039 Wrap-around: pc_out=0xFFFF_FFFC, no events -> pc_out=0x0000_0000 next cycle.
REQ-040 Halt/resume: halt_req at pc 0x40 -> HALT with pc_valid=0; redirect during HALT is ignored; resume -> RUN with pc_out=0x40 and pc_valid=1.
REQ-041 Asynchronous reset: assert rst_n=0 mid-cycle in RUN at pc 0x80 -> pc_out=0x0 and pc_valid=0 before the next clock edge.
